led_sequencer: RTL and testbench
================================

# led_sequencer

Pattern stage that sits directly downstream of the mode clock generator. It consumes the toggling `mode_clock` step signal and the 2-bit mode switch, and drives the 16 board LEDs with one of three animated patterns. Each rising edge of the step signal advances the pattern by one position. The block is fully synchronous to `SCLK`, replaces behavioural delays with a synchronizer and edge detector, and emits a one-cycle wrap pulse at the end of every pattern period.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `STEP`. Legal values are 2 or 3.
- `SCLK` input 1: system clock. All state changes on its rising edge.
- `RSTN` input 1: reset, asynchronous, active-low.
- `SW` input 2: mode select. 0 = off, 1 = chaser, 2 = bounce, 3 = fill/drain. Already debounced and synchronous to `SCLK`.
- `STEP` input 1: step clock from the mode clock generator. Asynchronous to `SCLK`, slow toggling level.
- `LD` output 16: LED drive, registered.
- `WRAP` output 1: one-`SCLK` pulse when the pattern completes a period, registered.

## Operation
- **STEP path**
  - `STEP` passes through `SYNC_STAGES` flops, then one history flop.
  - `step_p` = last sync stage AND NOT history.
  - Only rising edges of `STEP` advance the pattern. Falling edges are ignored.
- **Mode register**
  - `mode_q` (2 bits) registers `SW`.
  - When `SW != mode_q`: load `mode_q <= SW` and the initial state of the new mode. `step_p` is discarded in that cycle and `WRAP` = 0.
- **Initial states**
  - Mode 0: `LD` = 0x0000.
  - Mode 1: `LD` = 0x0001.
  - Mode 2: `LD` = 0x0001, `dir` = UP.
  - Mode 3: `LD` = 0x0000, `phase` = FILL.
- **Mode 0 (OFF):** `LD` holds 0x0000. Steps are ignored. `WRAP` never asserts.
- **Mode 1 (CHASE)**
  - On `step_p`: `LD` rotates left by 1.
  - 0x8000 → 0x0001 asserts `WRAP`. Period is 16 steps.
- **Mode 2 (BOUNCE)**, state `dir` ∈ {UP, DOWN}
  - UP: shift left. When `LD` = 0x8000, the next step sets `dir` = DOWN and `LD` = 0x4000 (same edge).
  - DOWN: shift right. When `LD` = 0x0001, the next step sets `dir` = UP and `LD` = 0x0002.
  - `WRAP` asserts on the 0x0002 → 0x0001 step. Period is 30 steps.
- **Mode 3 (BAR)**, state `phase` ∈ {FILL, DRAIN}
  - FILL: `LD <= {LD[14:0],1}`. At 0xFFFF the next step sets `phase` = DRAIN and `LD` = 0xFFFE.
  - DRAIN: `LD <= {LD[14:0],0}`. 0x8000 → 0x0000 asserts `WRAP`. At 0x0000 the next step sets `phase` = FILL and `LD` = 0x0001.
  - Period is 32 steps.
- `WRAP` is 0 in every cycle without a wrapping step.
- `LD` is always exactly one of the states listed above; no illegal encodings are reachable.
- `dir` and `phase` are don't-care outside modes 2 and 3 and are reinitialised on entry.

## Timing
- **Reset (`RSTN` low):** immediately, asynchronously:
  - `LD` = 0x0000, `WRAP` = 0, `mode_q` = 0.
  - All sync/history flops = 0; `dir` = UP; `phase` = FILL.
- **Reset release:** with `SW` ≠ 0, the first `SCLK` edge is a mode change and loads that mode's initial state.
- **Step latency:** a `STEP` rise sampled at edge N updates `LD`/`WRAP` at edge N+`SYNC_STAGES`, i.e. 2 cycles for the default.
- **Step rate:** one update per `STEP` rise. `STEP` high and low times must each be ≥ `SYNC_STAGES`+1 `SCLK` cycles; faster toggling is unsupported.
- **Simultaneous mode change and `step_p`:** the mode change wins. The new initial state is loaded and that step is lost.
- **Reset mid-pattern:** the state is lost. After release the block restarts from the initial state of `SW`.
- `STEP` held high produces no further steps.

## Test plan
- Reset with `SW`=1, `STEP`=0, release, wait 1 cycle → `LD`=0x0001. Apply 16 `STEP` rises → `LD` back at 0x0001, with `WRAP` high exactly once, for one cycle, on the 16th.
- `SW`=2, 15 `STEP` rises → `LD`=0x8000. One more → 0x4000. 29 total rises → 0x0002; the 30th → 0x0001 with `WRAP`=1.
- `SW`=3, 16 rises → 0xFFFF; 17th → 0xFFFE. 31st → 0x8000; 32nd → 0x0000 with `WRAP`; 33rd → 0x0001.
- Change `SW` 1→3 in the same cycle `step_p` is high while `LD`=0x0008 → next `LD`=0x0000, `WRAP`=0, step consumed. Then `SW`=0 → `LD`=0x0000, and 5 further rises leave it 0x0000.
- Latency: `STEP` rise sampled at edge N → `LD` changes exactly at edge N+2, and no change occurs on the `STEP` fall.
- Assert `RSTN` asynchronously (between edges) mid-bounce at 0x0100 → `LD`=0x0000 and `WRAP`=0 with no clock edge. Release with `SW`=2 → 0x0001, `dir`=UP.

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern stage: synchronizes the STEP clock, detects its rising edges and
// animates the 16 LEDs as off / chaser / bounce / fill-drain bar with a wrap pulse.
module led_sequencer #(
  parameter int SYNC_STAGES = 2  // 2 or 3
) (
  input  logic        SCLK,
  input  logic        RSTN,
  input  logic [1:0]  SW,
  input  logic        STEP,
  output logic [15:0] LD,
  output logic        WRAP
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BAR    = 2'd3;

  localparam logic DIR_UP     = 1'b0;
  localparam logic DIR_DOWN   = 1'b1;
  localparam logic PHASE_FILL  = 1'b0;
  localparam logic PHASE_DRAIN = 1'b1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   step_p;

  logic [1:0]  mode_reg, mode_next;
  logic [15:0] ld_reg, ld_next;
  logic        dir_reg, dir_next;
  logic        phase_reg, phase_next;
  logic        wrap_reg, wrap_next;

  // STEP is asynchronous: resynchronize before edge detection.
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], STEP};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign step_p = sync_reg[SYNC_STAGES-1] & ~hist_reg;

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      mode_reg  <= MODE_OFF;
      ld_reg    <= 16'h0000;
      dir_reg   <= DIR_UP;
      phase_reg <= PHASE_FILL;
      wrap_reg  <= 1'b0;
    end else begin
      mode_reg  <= mode_next;
      ld_reg    <= ld_next;
      dir_reg   <= dir_next;
      phase_reg <= phase_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    mode_next  = mode_reg;
    ld_next    = ld_reg;
    dir_next   = dir_reg;
    phase_next = phase_reg;
    wrap_next  = 1'b0;

    // A mode change takes priority and swallows any coincident step.
    if (SW != mode_reg) begin
      mode_next  = SW;
      ld_next    = (SW == MODE_CHASE || SW == MODE_BOUNCE) ? 16'h0001 : 16'h0000;
      dir_next   = DIR_UP;
      phase_next = PHASE_FILL;
    end else if (step_p) begin
      case (mode_reg)
        MODE_CHASE: begin
          ld_next   = {ld_reg[14:0], ld_reg[15]};
          wrap_next = (ld_reg == 16'h8000);
        end
        MODE_BOUNCE: begin
          if (dir_reg == DIR_UP) begin
            if (ld_reg == 16'h8000) begin
              dir_next = DIR_DOWN;
              ld_next  = 16'h4000;
            end else begin
              ld_next = ld_reg << 1;
            end
          end else begin
            if (ld_reg == 16'h0001) begin
              dir_next = DIR_UP;
              ld_next  = 16'h0002;
            end else begin
              ld_next = ld_reg >> 1;
            end
            wrap_next = (ld_reg == 16'h0002);
          end
        end
        MODE_BAR: begin
          if (phase_reg == PHASE_FILL) begin
            if (ld_reg == 16'hFFFF) begin
              phase_next = PHASE_DRAIN;
              ld_next    = 16'hFFFE;
            end else begin
              ld_next = {ld_reg[14:0], 1'b1};
            end
          end else begin
            if (ld_reg == 16'h0000) begin
              phase_next = PHASE_FILL;
              ld_next    = 16'h0001;
            end else begin
              ld_next = {ld_reg[14:0], 1'b0};
            end
            wrap_next = (ld_reg == 16'h8000);
          end
        end
        default: ld_next = 16'h0000;
      endcase
    end
  end

  always_comb begin
    LD   = ld_reg;
    WRAP = wrap_reg;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed and random STEP/mode stimulus, expected LED
// states from a position-based pattern model, checked by a cycle-accurate monitor.
module tb_led_sequencer;

  logic        SCLK = 1'b0;
  logic        RSTN = 1'b1;
  logic [1:0]  SW   = 2'd1;
  logic        STEP = 1'b0;
  logic [15:0] LD;
  logic        WRAP;

  led_sequencer #(.SYNC_STAGES(2)) dut (
    .SCLK(SCLK),
    .RSTN(RSTN),
    .SW  (SW),
    .STEP(STEP),
    .LD  (LD),
    .WRAP(WRAP)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic [15:0] ld;
    logic        wrap;
    int          due;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          next_id = 0;
  logic [15:0] last_ld = 16'h0000;

  // model state: current mode and position within that mode's period
  int mode_m = 0;
  int pos_m  = 0;

  function automatic int period(input int m);
    case (m)
      1: return 16;
      2: return 30;
      3: return 32;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] pat(input int m, input int p);
    int v;
    case (m)
      1: v = 1 << p;
      2: v = (p <= 15) ? (1 << p) : (1 << (30 - p));
      3: v = (p <= 16) ? ((1 << p) - 1) : (32'h0000FFFF << (p - 16));
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  task automatic push(input logic [15:0] ld, input logic wrap, input int due);
    exp_t e;
    e.ld = ld; e.wrap = wrap; e.due = due; e.id = next_id;
    next_id++;
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge SCLK);
    cyc++;
  end

  // Monitor: checks scheduled updates at their exact cycle, and that nothing moves otherwise.
  initial forever begin
    exp_t e;
    @(negedge SCLK);
    if (!RSTN) begin
      last_ld = LD;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.due != cyc || LD !== e.ld || WRAP !== e.wrap) begin
        fails++;
        $display("FAIL event%0d: cyc %0d LD=%h WRAP=%b, expected LD=%h WRAP=%b at cyc %0d",
                 e.id, cyc, LD, WRAP, e.ld, e.wrap, e.due);
      end else begin
        $display("[TB] event%0d cyc %0d LD=%h WRAP=%b ok", e.id, cyc, LD, WRAP);
      end
      last_ld = LD;
    end else begin
      tests++;
      if (LD !== last_ld || WRAP !== 1'b0) begin
        fails++;
        $display("FAIL hold: cyc %0d LD=%h WRAP=%b, expected LD=%h WRAP=0", cyc, LD, WRAP, last_ld);
      end
      last_ld = LD;
    end
  end

  task automatic do_step(input int hi, input int lo);
    @(negedge SCLK);
    STEP = 1'b1;
    if (mode_m != 0) pos_m = (pos_m + 1) % period(mode_m);
    push(pat(mode_m, pos_m), (mode_m != 0) && (pos_m == 0), cyc + 3);
    repeat (hi) @(negedge SCLK);
    STEP = 1'b0;
    repeat (lo - 1) @(negedge SCLK);
  endtask

  task automatic set_mode(input int m);
    @(negedge SCLK);
    SW = 2'(m);
    if (m != mode_m) begin
      mode_m = m;
      pos_m  = 0;
      push(pat(m, 0), 1'b0, cyc + 1);
    end
  endtask

  task automatic check_reset(input string tag);
    tests++;
    if (LD !== 16'h0000 || WRAP !== 1'b0) begin
      fails++;
      $display("FAIL %s: LD=%h WRAP=%b, expected LD=0000 WRAP=0", tag, LD, WRAP);
    end else begin
      $display("[TB] %s LD=%h WRAP=%b ok", tag, LD, WRAP);
    end
  endtask

  task automatic release_reset();
    @(negedge SCLK);
    RSTN   = 1'b1;
    mode_m = int'(SW);
    pos_m  = 0;
    if (mode_m != 0) push(pat(mode_m, 0), 1'b0, cyc + 1);
  endtask

  initial begin
    int c;
    #1 RSTN = 1'b0;
    #1 check_reset("reset_init");
    repeat (2) @(negedge SCLK);
    release_reset();

    repeat (16) do_step(4, 4);

    set_mode(2);
    repeat (30) do_step(3, 3);

    set_mode(3);
    repeat (33) do_step(3, 4);

    // mode change coincident with step_p while the chaser sits at 0x0008
    set_mode(1);
    repeat (3) do_step(4, 4);
    @(negedge SCLK);
    STEP = 1'b1;
    c = cyc;
    repeat (2) @(negedge SCLK);
    SW = 2'd3;
    mode_m = 3;
    pos_m  = 0;
    push(16'h0000, 1'b0, c + 3);
    repeat (3) @(negedge SCLK);
    STEP = 1'b0;
    repeat (4) @(negedge SCLK);

    set_mode(0);
    repeat (5) do_step(4, 4);

    // asynchronous reset in the middle of a bounce at 0x0100
    set_mode(2);
    repeat (8) do_step(4, 4);
    @(negedge SCLK);
    #2 RSTN = 1'b0;
    #1 check_reset("reset_async");
    repeat (2) @(negedge SCLK);
    release_reset();
    repeat (2) do_step(4, 4);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) set_mode(int'($urandom_range(0, 3)));
      else do_step(int'($urandom_range(3, 6)), int'($urandom_range(3, 6)));
    end

    repeat (10) @(negedge SCLK);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events still pending, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
